// File: rtl/noc_packet_injector_pkg.sv
// Shared NoC injector definitions: header/payload field offsets, FSM encodings, descriptor type.
package noc_packet_injector_pkg;

    localparam int NOC_DATA_WIDTH = 32;

    localparam int DEST_HI = 31;
    localparam int DEST_LO = 24;
    localparam int SRC_HI  = 23;
    localparam int SRC_LO  = 16;
    localparam int LEN_HI  = 15;
    localparam int LEN_LO  = 8;
    localparam int SEQ_HI  = 7;
    localparam int SEQ_LO  = 0;

    // Payload flits carry the packet seq in the SRC slot and the flit index below it
    localparam int PL_SEQ_HI = 23;
    localparam int PL_SEQ_LO = 16;
    localparam int PL_IDX_HI = 15;
    localparam int PL_IDX_LO = 0;

    localparam logic [1:0] INJ_IDLE = 2'd0;
    localparam logic [1:0] INJ_HEAD = 2'd1;
    localparam logic [1:0] INJ_BODY = 2'd2;

    typedef struct packed {
        logic [7:0] dest;
        logic [7:0] len;
        logic [7:0] seq;
    } inj_desc_t;

endpackage

// File: rtl/noc_flit_pack.sv
// Combinational flit formatter: header or payload flit from a packet descriptor and flit index.
module noc_flit_pack
    import noc_packet_injector_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH
) (
    input  logic                  is_header,
    input  logic [7:0]            src_id,
    input  inj_desc_t             desc,
    input  logic [7:0]            cnt,
    output logic [DATA_WIDTH-1:0] flit
);

    always_comb begin
        flit = '0;
        if (is_header) begin
            flit[DEST_HI:DEST_LO] = desc.dest;
            flit[SRC_HI:SRC_LO]   = src_id;
            flit[LEN_HI:LEN_LO]   = desc.len;
            flit[SEQ_HI:SEQ_LO]   = desc.seq;
        end else begin
            flit[PL_SEQ_HI:PL_SEQ_LO] = desc.seq;
            flit[PL_IDX_HI:PL_IDX_LO] = {8'h00, cnt};
        end
    end

endmodule

// File: rtl/noc_packet_injector.sv
// Transmit-side NI: serialises one descriptor into header + len payload flits on a valid/ready link.
module noc_packet_injector
    import noc_packet_injector_pkg::*;
#(
    parameter int         DATA_WIDTH = NOC_DATA_WIDTH,
    parameter logic [7:0] SRC_ID     = 8'd0
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_dest,
    input  logic [7:0]            req_len,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic                  pkt_done,
    output logic [15:0]           pkt_count
);

    logic [1:0]            state, state_n;
    inj_desc_t             desc, desc_n;
    logic [7:0]            seq, seq_n;
    logic [7:0]            cnt, cnt_n;
    logic                  accept, xfer, tail_xfer, tail_n;
    logic [DATA_WIDTH-1:0] flit_raw;

    assign accept    = req_valid & req_ready;
    assign xfer      = sender_valid & sender_ready;
    assign tail_xfer = xfer & sender_is_tail;

    always_comb begin
        state_n = state;
        desc_n  = desc;
        seq_n   = seq;
        cnt_n   = cnt;
        case (state)
            INJ_IDLE: if (accept) begin
                state_n     = INJ_HEAD;
                desc_n.dest = req_dest;
                desc_n.len  = req_len;
                desc_n.seq  = seq;
                seq_n       = seq + 8'd1;
            end
            INJ_HEAD: if (xfer) begin
                state_n = (desc.len == 8'd0) ? INJ_IDLE : INJ_BODY;
                cnt_n   = 8'd0;
            end
            INJ_BODY: if (xfer) begin
                if (sender_is_tail) state_n = INJ_IDLE;
                else                cnt_n   = cnt + 8'd1;
            end
            default: state_n = INJ_IDLE;
        endcase
    end

    // Outputs are computed from next-state values so every output is a flop;
    // a stall leaves next == current, which holds the flit and flags.
    always_comb begin
        tail_n = 1'b0;
        if (state_n == INJ_HEAD)      tail_n = (desc_n.len == 8'd0);
        else if (state_n == INJ_BODY) tail_n = (cnt_n == desc_n.len - 8'd1);
    end

    noc_flit_pack #(.DATA_WIDTH(DATA_WIDTH)) u_pack (
        .is_header (state_n == INJ_HEAD),
        .src_id    (SRC_ID),
        .desc      (desc_n),
        .cnt       (cnt_n),
        .flit      (flit_raw)
    );

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state            <= INJ_IDLE;
            desc             <= '0;
            seq              <= 8'd0;
            cnt              <= 8'd0;
            req_ready        <= 1'b0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
            pkt_done         <= 1'b0;
            pkt_count        <= 16'd0;
        end else begin
            state            <= state_n;
            desc             <= desc_n;
            seq              <= seq_n;
            cnt              <= cnt_n;
            req_ready        <= (state_n == INJ_IDLE);
            sender_valid     <= (state_n != INJ_IDLE);
            sender_flit      <= (state_n == INJ_IDLE) ? '0 : flit_raw;
            sender_is_header <= (state_n == INJ_HEAD);
            sender_is_tail   <= tail_n;
            pkt_done         <= tail_xfer;
            pkt_count        <= pkt_count + 16'(tail_xfer);
        end
    end

endmodule

// File: doc/noc_packet_injector.md
# noc_packet_injector

Transmit-side network interface for the NoC. Accepts one packet descriptor at a time (destination, payload length) and serialises it into a header flit plus N payload flits on the same `sender_*` valid/ready flit interface that router ports and nodes receive on. It sits between a local traffic source or test harness and a router input port. It is the flit producer that a receiving node consumes.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `Noc_Data_Width `` (32): flit width; must be ≥ 32.
- `SRC_ID`, default 0: 8-bit source node ID written into every header.

Ports (one clock; reset is asynchronous and active-high):
- `noc_clk`  in  1  NoC clock.
- `noc_rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  descriptor valid.
- `req_ready`  out  1  descriptor accepted when `req_valid & req_ready`.
- `req_dest`  in  8  destination node ID.
- `req_len`  in  8  payload flit count, 0..255.
- `sender_valid`  out  1  flit valid.
- `sender_ready`  in  1  downstream accepts flit.
- `sender_flit`  out  DATA_WIDTH  flit data.
- `sender_is_header`  out  1  current flit is the header.
- `sender_is_tail`  out  1  current flit is the last flit of the packet.
- `pkt_done`  out  1  one-cycle pulse when the tail flit transfers.
- `pkt_count`  out  16  packets fully sent; wraps 65535→0.

## Operation
- FSM states: IDLE, HEAD, BODY.
- IDLE:
  - `req_ready`=1, `sender_valid`=0.
  - On `req_valid`, latch `dest` and `len`, capture current `seq`, increment `seq` (8-bit, wraps 255→0), then go to HEAD.
- HEAD:
  - `sender_valid`=1, `sender_is_header`=1, `sender_is_tail`=(len==0).
  - Header flit: [31:24]=dest, [23:16]=SRC_ID, [15:8]=len, [7:0]=seq. Bits above 31 are zero.
  - On transfer: if len==0, go to IDLE; otherwise go to BODY with `cnt`=0.
- BODY:
  - `sender_valid`=1, `sender_is_header`=0, `sender_is_tail`=(cnt==len-1).
  - Payload flit k: [23:16]=seq, [15:0]=k. All other bits are zero.
  - On transfer: `cnt`++. The tail transfer returns to IDLE.
- `req_ready`=0 in HEAD and BODY. Descriptors are not queued.
- Handshake rules:
  - A transfer happens only on `sender_valid & sender_ready`.
  - Once `sender_valid` is raised, `sender_flit`, `sender_is_header` and `sender_is_tail` hold stable until transfer.
  - `sender_valid` never drops without a transfer.
- `pkt_done` pulses and `pkt_count` increments on the cycle after the tail transfer (registered).
- Boundary conditions:
  - len=0: a single flit with both `sender_is_header` and `sender_is_tail` set.
  - len=255: cnt reaches 254 on the tail flit; no overflow of an 8-bit `cnt`.
  - Stall: `sender_ready` low in any state freezes the FSM and all outputs.
- Reset (async, any time, including mid-packet):
  - All outputs go to 0 immediately: `sender_valid`, `sender_flit`, flags, `pkt_done`, `pkt_count`, and `req_ready`.
  - State becomes IDLE; `seq` and `cnt` become 0.
  - `req_ready` rises on the first clock after deassertion.
  - A truncated packet is not completed; the downstream is reset alongside.

## Timing
- All outputs are registered.
- Descriptor accepted at edge t → header valid from t+1.
- With `sender_ready` held high:
  - Payload flit k is valid in cycle t+2+k.
  - Tail transfers at t+1+len.
  - `req_ready` is high again at t+2+len.
  - `pkt_done` pulses at t+2+len.
- Minimum packet period is len+2 cycles: one IDLE cycle between packets.
- Throughput within a packet is one flit per cycle.

## Structure
- Add to `Noc_parameters.v`:
  - header field offsets (DEST_HI/LO, SRC_HI/LO, LEN_HI/LO, SEQ_HI/LO);
  - FSM state encodings (`INJ_IDLE`, `INJ_HEAD`, `INJ_BODY`).
- One combinational sub-module, `noc_flit_pack`: maps (is_header, dest, SRC_ID, len, seq, cnt) to `DATA_WIDTH` flit bits. It is reusable by the receive-side checker. Its output is registered in the injector.

## Test plan
- Reset, then req dest=0x05, len=3, `sender_ready`=1 → flits 0x0500_0300, 0x0000_0000, 0x0000_0001, 0x0000_0002 in consecutive cycles; header flag on the first only, tail flag on the last only; `pkt_done` one cycle later; `pkt_count`=1.
- len=0, dest=0xA0 → a single flit 0xA000_0000 with `sender_is_header`=`sender_is_tail`=1; the next packet's header carries seq=1.
- len=4 with `sender_ready` toggling 1,0,0,1,0,1… → flit and flags stable through every stall; exactly 5 transfers in order; no duplicated or skipped k.
- Back-to-back `req_valid` held high → `req_ready` low for len+1 cycles per packet; each descriptor is accepted exactly once; seq increments 0,1,2.
- Send 257 packets of len=1 → header seq field wraps 0xFF→0x00; `pkt_count`=257.
- Assert `noc_rst` at payload k=2 of a len=8 packet → `sender_valid`=0 asynchronously (same cycle, before the next edge); after release the next header carries seq=0 and `pkt_count`=0.
